// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the two-requester register-file arbiter:
// controller state encoding and requester identifiers.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic ReqA = 1'b0;
  localparam logic ReqB = 1'b1;

endpackage

// File: rtl/regfile_arb_rr.sv
// Round-robin winner selection between requesters A and B.
// Optional feature macro REGARB_LOCK_EN: the last-granted requester keeps the
// grant while it holds its lock input and is still requesting.
module regfile_arb_rr
  import regfile_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last,
`ifdef REGARB_LOCK_EN
  input  logic a_lock,
  input  logic b_lock,
`endif
  output logic winner
);

  // Pick the requester that did not win last time when both are asking.
  always_comb begin
    winner = ReqA;
    if (a_req && b_req) begin
      winner = (last == ReqB) ? ReqA : ReqB;
    end else if (b_req) begin
      winner = ReqB;
    end
`ifdef REGARB_LOCK_EN
    if (last == ReqA && a_lock && a_req) begin
      winner = ReqA;
    end else if (last == ReqB && b_lock && b_req) begin
      winner = ReqB;
    end
`endif
  end

endmodule

// File: rtl/regfile_arb.sv
// Arbiter granting two requesters serialized access to an external register
// file. Each transaction takes IDLE -> ACCESS -> DONE; the winner and its
// request fields are latched at grant so later input changes are ignored.
// Optional feature macro REGARB_LOCK_EN adds a_lock/b_lock grant holding.
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_num,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_num,
  input  logic [DW-1:0] b_wdata,
`ifdef REGARB_LOCK_EN
  input  logic          a_lock,
  input  logic          b_lock,
`endif
  input  logic [DW-1:0] rf_data_out,
  output logic          a_ack,
  output logic          b_ack,
  output logic [DW-1:0] rdata,
  output logic          rf_write,
  output logic [AW-1:0] rf_writenum,
  output logic [AW-1:0] rf_readnum,
  output logic [DW-1:0] rf_data_in
);

  state_e        state_q, state_d;
  logic          last_q;
  logic          win_q;
  logic          wr_q;
  logic [AW-1:0] num_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          winner;
  logic          any_req;

  assign any_req = a_req | b_req;

  regfile_arb_rr u_rr (
    .a_req  (a_req),
    .b_req  (b_req),
    .last   (last_q),
`ifdef REGARB_LOCK_EN
    .a_lock (a_lock),
    .b_lock (b_lock),
`endif
    .winner (winner)
  );

  // Next-state logic for the three-phase transaction sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register; reset drops straight back to idle, aborting any access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch winner and its transaction at grant; capture read data on leaving ACCESS.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q  <= ReqB;
      win_q   <= ReqA;
      wr_q    <= 1'b0;
      num_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == StIdle && any_req) begin
        last_q  <= winner;
        win_q   <= winner;
        wr_q    <= (winner == ReqA) ? a_wr    : b_wr;
        num_q   <= (winner == ReqA) ? a_num   : b_num;
        wdata_q <= (winner == ReqA) ? a_wdata : b_wdata;
      end
      if (state_q == StAccess && !wr_q) begin
        rdata_q <= rf_data_out;
      end
    end
  end

  // Register-file drive only during ACCESS; acks only during DONE.
  always_comb begin
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_readnum  = '0;
    rf_data_in  = '0;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    if (state_q == StAccess) begin
      rf_write    = wr_q;
      rf_writenum = num_q;
      rf_readnum  = num_q;
      rf_data_in  = wdata_q;
    end
    if (state_q == StDone) begin
      a_ack = (win_q == ReqA);
      b_ack = (win_q == ReqB);
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_regfile_arb.sv
// Self-checking bench for regfile_arb: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
// Lock sequence is built only when REGARB_LOCK_EN is defined.
module tb_regfile_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic        a_wr = 1'b0, b_wr = 1'b0;
  logic [2:0]  a_num = '0, b_num = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;
  logic        a_lock = 1'b0, b_lock = 1'b0;
  logic [15:0] rf_data_out;
  logic        a_ack, b_ack;
  logic [15:0] rdata;
  logic        rf_write;
  logic [2:0]  rf_writenum, rf_readnum;
  logic [15:0] rf_data_in;

  int checks = 0;
  int failures = 0;

  // External register file owned by the bench.
  logic [15:0] rf_mem [8];
  initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
  always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
  assign rf_data_out = rf_mem[rf_readnum];

  always #5 clk = ~clk;

  regfile_arb dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a_req       (a_req),
    .a_wr        (a_wr),
    .a_num       (a_num),
    .a_wdata     (a_wdata),
    .b_req       (b_req),
    .b_wr        (b_wr),
    .b_num       (b_num),
    .b_wdata     (b_wdata),
`ifdef REGARB_LOCK_EN
    .a_lock      (a_lock),
    .b_lock      (b_lock),
`endif
    .rf_data_out (rf_data_out),
    .a_ack       (a_ack),
    .b_ack       (b_ack),
    .rdata       (rdata),
    .rf_write    (rf_write),
    .rf_writenum (rf_writenum),
    .rf_readnum  (rf_readnum),
    .rf_data_in  (rf_data_in)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reset pulse; returns 1ns after a rising edge with the DUT idle.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic who, input logic wr, input logic [2:0] num,
                         input logic [15:0] wd);
    if (who == 1'b0) begin
      a_req = 1'b1; a_wr = wr; a_num = num; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_wr = wr; b_num = num; b_wdata = wd;
    end
  endtask

  // Single-requester transaction from idle with cycle-exact checks.
  task automatic txn(input logic who, input logic wr, input logic [2:0] num,
                     input logic [15:0] wd, input logic [15:0] exp_rd);
    set_req(who, wr, num, wd);
    @(posedge clk); #1;
    chk("acc_rf_write", rf_write, wr);
    if (wr) begin
      chk("acc_writenum", rf_writenum, num);
      chk("acc_data_in", rf_data_in, wd);
    end else begin
      chk("acc_readnum", rf_readnum, num);
    end
    chk("acc_no_ack", {a_ack, b_ack}, 2'b00);
    @(posedge clk); #1;
    chk("done_ack", {a_ack, b_ack}, (who == 1'b0) ? 2'b10 : 2'b01);
    chk("done_rdata", rdata, exp_rd);
    chk("done_rf_write", rf_write, 1'b0);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    chk("post_ack", {a_ack, b_ack}, 2'b00);
  endtask

  typedef struct {
    logic        who;
    logic        wr;
    logic [2:0]  num;
    logic [15:0] wd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Reset state, sampled while reset is held.
    #12;
    chk("rst_ack", {a_ack, b_ack}, 2'b00);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_rf_write", rf_write, 1'b0);
    chk("rst_rf_nums", {rf_writenum, rf_readnum}, 6'h0);
    chk("rst_rf_data_in", rf_data_in, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{1'b0, 1'b1, 3'd3, 16'h1234, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 3'd6, 16'hABCD, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 3'd6, 16'h0000, 16'hABCD};
    vecs[4] = '{1'b0, 1'b1, 3'd0, 16'h5555, 16'hABCD};
    vecs[5] = '{1'b1, 1'b0, 3'd0, 16'h0000, 16'h5555};
    for (int i = 0; i < 6; i++) begin
      txn(vecs[i].who, vecs[i].wr, vecs[i].num, vecs[i].wd, vecs[i].exp_rd);
    end

    // Simultaneous requests from reset: A (write R5) first, then B (read R5).
    do_reset();
    set_req(1'b0, 1'b1, 3'd5, 16'h00FF);
    set_req(1'b1, 1'b0, 3'd5, 16'h0000);
    @(posedge clk); #1;
    chk("sim_a_write", {rf_write, rf_writenum}, {1'b1, 3'd5});
    chk("sim_a_data", rf_data_in, 16'h00FF);
    @(posedge clk); #1;
    chk("sim_a_ack", {a_ack, b_ack}, 2'b10);
    a_req = 1'b0;
    @(posedge clk); #1;
    chk("sim_gap", {a_ack, b_ack}, 2'b00);
    @(posedge clk); #1;
    chk("sim_b_read", {rf_write, rf_readnum}, {1'b0, 3'd5});
    @(posedge clk); #1;
    chk("sim_b_ack", {a_ack, b_ack}, 2'b01);
    chk("sim_b_rdata", rdata, 16'h00FF);
    b_req = 1'b0;
    @(posedge clk); #1;

    // Reset during ACCESS aborts a write of BEEF to R1.
    txn(1'b0, 1'b1, 3'd1, 16'h1111, 16'h00FF);
    set_req(1'b0, 1'b1, 3'd1, 16'hBEEF);
    @(posedge clk); #1;
    chk("abort_access", rf_write, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_rf_write", rf_write, 1'b0);
    chk("abort_writenum", rf_writenum, 3'd0);
    chk("abort_rdata", rdata, 16'h0);
    a_req = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", {a_ack, b_ack}, 2'b00);
    end
    txn(1'b0, 1'b0, 3'd1, 16'h0000, 16'h1111);

`ifdef REGARB_LOCK_EN
    // Lock: A granted last, holds lock and req; B waits for three A acks.
    begin
      logic order [$];
      int   a_cnt = 0;
      do_reset();
      txn(1'b0, 1'b1, 3'd2, 16'h0202, 16'h0000);
      set_req(1'b0, 1'b0, 3'd2, 16'h0000);
      set_req(1'b1, 1'b0, 3'd2, 16'h0000);
      a_lock = 1'b1;
      for (int c = 0; c < 30 && order.size() < 4; c++) begin
        @(posedge clk); #1;
        if (a_ack) begin
          order.push_back(1'b0);
          a_cnt++;
          if (a_cnt == 3) begin
            a_lock = 1'b0;
            a_req  = 1'b0;
          end
        end
        if (b_ack) begin
          order.push_back(1'b1);
          b_req = 1'b0;
        end
      end
      chk("lock_ack_count", order.size(), 4);
      if (order.size() == 4) begin
        chk("lock_order", {order[0], order[1], order[2], order[3]}, 4'b0001);
      end
      a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0;
      @(posedge clk); #1;
    end
`endif

    // Randomized traffic against a transaction-level model.
    begin
      logic [15:0] mmem [8];
      int          next_free = 0;
      int          grant_e = -10;
      logic        ptr = 1'b1;
      logic        g_win = 1'b0, g_wr = 1'b0;
      logic [2:0]  g_num = '0;
      logic [15:0] m_rdata = 16'h0;
      logic [15:0] m_pend = 16'h0;
      bit          a_cool = 1'b0, b_cool = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) mmem[i] = rf_mem[i];
      for (int e = 0; e < 600; e++) begin
        @(posedge clk);
        // A grant is possible once the previous three-cycle slot has ended.
        if (e >= next_free && (a_req || b_req)) begin
          if (a_req && b_req) g_win = (ptr == 1'b1) ? 1'b0 : 1'b1;
          else g_win = b_req;
          ptr       = g_win;
          grant_e   = e;
          next_free = e + 3;
          g_wr      = g_win ? b_wr : a_wr;
          g_num     = g_win ? b_num : a_num;
          if (g_wr) mmem[g_num] = g_win ? b_wdata : a_wdata;
          else m_pend = mmem[g_num];
        end
        #1;
        if (e == grant_e) begin
          chk("rnd_rf_write", rf_write, g_wr);
          chk("rnd_rf_num", g_wr ? rf_writenum : rf_readnum, g_num);
        end
        if (e == grant_e + 1) begin
          if (!g_wr) m_rdata = m_pend;
          chk("rnd_ack", {a_ack, b_ack}, g_win ? 2'b01 : 2'b10);
          chk("rnd_rdata", rdata, m_rdata);
        end else begin
          chk("rnd_no_ack", {a_ack, b_ack}, 2'b00);
        end
        // Requesters: drop after ack, stay low one more cycle, then maybe retry.
        if (e == grant_e + 1 && g_win == 1'b0) begin
          a_req = 1'b0; a_cool = 1'b1;
        end else if (!a_req) begin
          if (a_cool) a_cool = 1'b0;
          else if ($urandom_range(2) == 0)
            set_req(1'b0, 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom));
        end
        if (e == grant_e + 1 && g_win == 1'b1) begin
          b_req = 1'b0; b_cool = 1'b1;
        end else if (!b_req) begin
          if (b_cool) b_cool = 1'b0;
          else if ($urandom_range(2) == 0)
            set_req(1'b1, 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
- REQ-001: Parameter DW, default 16, data width of the shared register file.
- REQ-002: Parameter AW, default 3, register index width (8 registers).
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: a_req, b_req  input  1 each  requester A/B transaction request, level, held until ack.
- REQ-006: a_wr, b_wr  input  1 each  1 = write, 0 = read; stable while req high.
- REQ-007: a_num, b_num  input  AW each  target register index; stable while req high.
- REQ-008: a_wdata, b_wdata  input  DW each  write data; stable while req high.
- REQ-009: a_ack, b_ack  output  1 each  one-cycle completion pulse.
- REQ-010: rdata  output  DW  read result, valid in the ack cycle, held until the next ack.
- REQ-011: rf_write  output  1  register file write enable.
- REQ-012: rf_writenum, rf_readnum  output  AW each  register file write/read indices.
- REQ-013: rf_data_in  output  DW  register file write data.
- REQ-014: rf_data_out  input  DW  register file combinational read data.
- REQ-015: a_lock, b_lock  input  1 each  hold grant across back-to-back transactions (present only with REGARB_LOCK_EN).

Function
- REQ-016: FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when any req high; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
- REQ-017: Winner latched on the IDLE->ACCESS edge together with its wr, num and wdata; later input changes do not affect the latched transaction.
- REQ-018: Arbitration round-robin: the last-granted pointer (reset to B) gives priority to the other requester when both req are high.
- REQ-019: In ACCESS: rf_readnum = rf_writenum = latched num, rf_data_in = latched wdata, rf_write = latched wr; rf_write is 0 in all other states.
- REQ-020: Read: rf_data_out sampled into rdata on the ACCESS->DONE edge; a write leaves rdata unchanged.
- REQ-021: In DONE the winner's ack is 1 for exactly one cycle; the other ack stays 0.
- REQ-022: Latency: req sampled high in IDLE at edge N -> ACCESS during cycle N+1 -> ack during cycle N+2; minimum 3 cycles per transaction.
- REQ-023: A requester deasserts req in the cycle after ack; a req still high in IDLE starts a new transaction.
- REQ-024: Simultaneous A write and B read of the same register: the grant order decides; the later transaction sees the earlier write.
- REQ-025: Outside ACCESS, rf_readnum/rf_writenum/rf_data_in are driven 0.

Reset
- REQ-026: reset_n low forces state IDLE, pointer B, rdata 0, both acks 0, rf_write 0, all rf_* indices and data 0, immediately and independent of clk.
- REQ-027: Reset asserted during ACCESS aborts the transaction: no write commits after reset assertion and no ack issues for it.

Configuration
- REQ-028: Macro REGARB_LOCK_EN defined: a_lock/b_lock ports exist; if the requester granted last has lock=1 and req=1 in IDLE, it wins regardless of the round-robin pointer.
- REQ-029: Macro REGARB_LOCK_EN undefined: lock ports absent; pure round-robin.

Structure
- REQ-030: A shared package holds the state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the requester-ID constants (REQ_A=1'b0, REQ_B=1'b1).
- REQ-031: One sub-module, regfile_arb_rr, computes the round-robin winner from both reqs, the pointer and the lock inputs; the register file itself is instantiated outside this block.

Verification
- REQ-032: After reset, A writes 16'h1234 to R3 -> rf_write=1 with rf_writenum=3 for one cycle, a_ack 2 cycles after req sampled, rdata stays 0.
- REQ-033: A then reads R3 -> rf_readnum=3 in ACCESS, a_ack with rdata=16'h1234.
- REQ-034: A and B request in the same cycle from reset -> A served first (pointer B), then B; acks alternate A,B.
- REQ-035: A writes 16'h00FF to R5 and B reads R5 in the same cycle -> B's ack carries rdata=16'h00FF.
- REQ-036: reset_n pulsed low during ACCESS of a write of 16'hBEEF to R1 -> no ack issued, a subsequent read of R1 does not return 16'hBEEF.
- REQ-037: With REGARB_LOCK_EN, A holds a_lock=1 and req=1 across 3 transactions while b_req=1 -> three a_acks before the first b_ack.
